// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter.
// Optional idle-owner timeout is compiled in by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
`ifdef UART_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 1024,
`endif
   parameter int IDW            = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 tx_rdy,
   output logic                 tx_wen,
   output logic [7:0]           tx_data,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      HOLD
   } state_t;

   state_t         state, state_n;
   logic [IDW-1:0] rr, rr_n;
   logic [IDW-1:0] gid_n;
   logic [IDW-1:0] win, scan;
   logic           any;
   logic           busy_n;
   logic           wen_n;
   logic [7:0]     data_n;
   logic           last_q, last_n;
   logic           hold_q, hold_n;
   logic           accept;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] tcnt, tcnt_n;
   logic          terr_n;
`else
   assign timeout_err = 1'b0;
`endif

   // first valid lane after the last owner, wrapping at NUM_REQ
   always_comb begin
      win  = '0;
      any  = 1'b0;
      scan = rr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (scan == IDW'(NUM_REQ - 1)) scan = '0;
         else scan = scan + 1'b1;
         if (!any && req_valid[scan]) begin
            win = scan;
            any = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == GRANT) req_ready[grant_id] = tx_rdy;
   end

   assign accept = (state == GRANT) && req_valid[grant_id] && tx_rdy;

   always_comb begin
      state_n = state;
      gid_n   = grant_id;
      rr_n    = rr;
      busy_n  = busy;
      wen_n   = 1'b0;
      data_n  = tx_data;
      last_n  = last_q;
      hold_n  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tcnt_n  = '0;
      terr_n  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (any) begin
               gid_n   = win;
               busy_n  = 1'b1;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               data_n  = req_data[8*grant_id +: 8];
               wen_n   = 1'b1;
               last_n  = req_last[grant_id];
               state_n = HOLD;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!req_valid[grant_id]) begin
               if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  rr_n    = grant_id;
                  terr_n  = 1'b1;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
`endif
         end
         HOLD: begin
            // tx_rdy is stale here, so the second cycle is a fixed wait
            if (!hold_q) begin
               hold_n = 1'b1;
            end else if (last_q) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               rr_n    = grant_id;
            end else begin
               state_n = GRANT;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         grant_id <= '0;
         rr       <= IDW'(NUM_REQ - 1);
         busy     <= 1'b0;
         tx_wen   <= 1'b0;
         tx_data  <= 8'h00;
         last_q   <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         state    <= state_n;
         grant_id <= gid_n;
         rr       <= rr_n;
         busy     <= busy_n;
         tx_wen   <= wen_n;
         tx_data  <= data_n;
         last_q   <= last_n;
         hold_q   <= hold_n;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         tcnt        <= tcnt_n;
         timeout_err <= terr_n;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random packet traffic against a queue-based
// round-robin model, plus directed stall, reset and timeout cases.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO  = 16;
`endif

   logic           CLK = 1'b0;
   logic           RESET;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_rdy;
   logic           tx_wen;
   logic [7:0]     tx_data;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic           timeout_err;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(
      .NUM_REQ(N),
`ifdef UART_ARB_TIMEOUT_EN
      .TIMEOUT_CYCLES(TO),
`endif
      .IDW(IDW)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_last(req_last),
      .req_ready(req_ready),
      .tx_rdy(tx_rdy),
      .tx_wen(tx_wen),
      .tx_data(tx_data),
      .grant_id(grant_id),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   typedef struct {
      int         lane;
      logic [7:0] d;
      bit         last;
   } ent_t;

   ent_t pend[$];
   ent_t mq[$];
   ent_t expq[$];
   int   model_rr;
   int   errs = 0;
   int   checks = 0;
   int   bad_rdy = 0;
   int   terr_seen = 0;
   bit   midpkt[N];
   int   gaprun[N];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic int first_in(input bit from_pend, input int ln);
      if (from_pend) begin
         for (int j = 0; j < pend.size(); j++)
            if (pend[j].lane == ln) return j;
      end else begin
         for (int j = 0; j < mq.size(); j++)
            if (mq[j].lane == ln) return j;
      end
      return -1;
   endfunction

   // whole-packet round robin over lanes that still have bytes queued
   function automatic void build_exp();
      mq = pend;
      while (mq.size() > 0) begin
         int ln;
         bit done;
         ln = -1;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (model_rr + k) % N;
            if (ln < 0 && first_in(0, c) >= 0) ln = c;
         end
         done = 1'b0;
         while (!done) begin
            int j;
            j = first_in(0, ln);
            if (j < 0) begin
               done = 1'b1;
            end else begin
               expq.push_back(mq[j]);
               done = mq[j].last;
               mq.delete(j);
            end
         end
         model_rr = ln;
      end
   endfunction

   task automatic add_pkt(input int lane, input int len);
      for (int b = 0; b < len; b++) begin
         ent_t e;
         e.lane = lane;
         e.d    = 8'($urandom);
         e.last = (b == len - 1);
         pend.push_back(e);
      end
   endtask

   task automatic add_byte(input int lane, input logic [7:0] d,
                           input bit last);
      ent_t e;
      e.lane = lane;
      e.d    = d;
      e.last = last;
      pend.push_back(e);
   endtask

   task automatic do_reset();
      RESET     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_rdy    = 1'b0;
      repeat (3) @(negedge CLK);
      RESET     = 1'b0;
      model_rr  = N - 1;
      for (int i = 0; i < N; i++) begin
         midpkt[i] = 1'b0;
         gaprun[i] = 0;
      end
   endtask

   task automatic run_traffic(input int budget, input bit gaps,
                              input int rdy_pct);
      int cyc, lastw;
      bit havew, prevlast;
      build_exp();
      cyc = 0;
      lastw = 0;
      havew = 1'b0;
      prevlast = 1'b0;
      while ((expq.size() > 0 || busy) && cyc < budget) begin
         @(negedge CLK);
         if (tx_wen) begin
            if (havew) begin
               chk("wen_spacing_min", 32'(cyc - lastw >= 3), 1);
               if (rdy_pct == 100 && !gaps)
                  chk("wen_spacing", cyc - lastw, prevlast ? 4 : 3);
            end
            if (expq.size() > 0) begin
               chk("tx_data", tx_data, expq[0].d);
               chk("wen_owner", grant_id, expq[0].lane);
               prevlast = expq[0].last;
               void'(expq.pop_front());
            end else begin
               chk("unexpected_wen", tx_wen, 0);
            end
            havew = 1'b1;
            lastw = cyc;
         end
         if (havew && prevlast && cyc == lastw + 1)
            chk("busy_hold", busy, 1);
         if (havew && prevlast && cyc == lastw + 2)
            chk("busy_release", busy, 0);
         if (timeout_err) terr_seen++;
         if ($countones(req_ready) > 1 || (req_ready != 0 && !tx_rdy))
            bad_rdy++;
         tx_rdy = ($urandom_range(99) < rdy_pct);
         for (int i = 0; i < N; i++) begin
            int j;
            j = first_in(1, i);
            if (j >= 0) begin
               req_data[8*i +: 8] = pend[j].d;
               req_last[i] = pend[j].last;
               req_valid[i] = 1'b1;
               if (gaps && midpkt[i] && gaprun[i] < 4 &&
                   $urandom_range(3) == 0) begin
                  req_valid[i] = 1'b0;
                  gaprun[i]++;
               end else begin
                  gaprun[i] = 0;
               end
            end else begin
               req_valid[i] = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i] = 1'($urandom);
            end
         end
         #1;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               int j;
               j = first_in(1, i);
               midpkt[i] = !pend[j].last;
               pend.delete(j);
            end
         end
         cyc++;
      end
      chk("drain", expq.size(), 0);
      chk("pend_end", pend.size(), 0);
      chk("busy_end", busy, 0);
      expq.delete();
      pend.delete();
      req_valid = '0;
   endtask

   initial begin
      logic [7:0] rb [4];
      int nw, k, bad, bad2, tcyc;
      bit acc;

      do_reset();
      chk("rst_grant_id", grant_id, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_timeout", timeout_err, 0);
      repeat (20) begin
         @(negedge CLK);
         chk("idle_wen", tx_wen, 0);
         chk("idle_busy", busy, 0);
         chk("idle_ready", req_ready, 0);
      end

      // all four lanes queued: order 0,1,2,3,0
      add_pkt(0, 1);
      add_pkt(1, 1);
      add_pkt(2, 1);
      add_pkt(3, 1);
      add_pkt(0, 1);
      run_traffic(200, 0, 100);

      add_byte(0, 8'h41, 0);
      add_byte(0, 8'h42, 0);
      add_byte(0, 8'h43, 1);
      run_traffic(100, 0, 100);

      // transmitter not ready for 50 cycles while lane 1 owns the grant
      req_valid = 4'b0010;
      req_data[15:8] = 8'h5A;
      req_last = 4'b0010;
      tx_rdy = 1'b0;
      bad = 0;
      bad2 = 0;
      repeat (50) begin
         @(negedge CLK);
         if (req_ready != 0 || tx_wen) bad++;
         if (!busy || grant_id != 1) bad2++;
      end
      chk("stall_quiet", bad, 0);
      chk("stall_owner", bad2, 0);
      tx_rdy = 1'b1;
      #1;
      chk("stall_ready", req_ready, 4'b0010);
      @(negedge CLK);
      chk("stall_wen", tx_wen, 1);
      chk("stall_data", tx_data, 8'h5A);
      req_valid = '0;
      repeat (3) @(negedge CLK);
      chk("stall_release", busy, 0);
      model_rr = 1;

      // reset during the hold of byte 2 of a 4-byte packet
      rb[0] = 8'hC0;
      rb[1] = 8'hC1;
      rb[2] = 8'hC2;
      rb[3] = 8'hC3;
      nw = 0;
      k = 0;
      tx_rdy = 1'b1;
      for (int c = 0; c < 40 && nw < 2; c++) begin
         @(negedge CLK);
         if (tx_wen) begin
            chk("rst_pkt_data", tx_data, rb[nw]);
            nw++;
         end
         if (nw < 2) begin
            req_valid = 4'b1000;
            req_data[31:24] = rb[k];
            req_last = (k == 3) ? 4'b1000 : 4'b0000;
            #1;
            if (req_ready[3]) k++;
         end
      end
      chk("rst_reach_hold", nw, 2);
      RESET = 1'b1;
      req_valid = '0;
      @(negedge CLK);
      chk("midrst_wen", tx_wen, 0);
      chk("midrst_data", tx_data, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_grant", grant_id, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_terr", timeout_err, 0);
      RESET = 1'b0;
      model_rr = N - 1;
      for (int i = 0; i < N; i++) midpkt[i] = 1'b0;
      add_pkt(2, 1);
      run_traffic(100, 0, 100);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++)
               add_pkt(i, $urandom_range(1, 4));
         end
         if (pend.size() == 0) add_pkt($urandom_range(0, N - 1), 2);
         run_traffic(4000, r[0], (r == 0) ? 100 : $urandom_range(30, 100));
      end

`ifdef UART_ARB_TIMEOUT_EN
      // owner stalls after its first byte; lane 1 waits
      req_valid = 4'b0001;
      req_data[7:0] = 8'hAA;
      req_last = '0;
      tx_rdy = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge CLK);
         #1;
         if (req_ready[0]) acc = 1'b1;
      end
      @(negedge CLK);
      chk("to_first_wen", tx_wen, 1);
      req_valid = 4'b0010;
      req_data[15:8] = 8'hB1;
      req_last = 4'b0010;
      tcyc = -1;
      for (int c = 1; c <= 40 && tcyc < 0; c++) begin
         @(negedge CLK);
         if (timeout_err) tcyc = c;
      end
      chk("to_delay", tcyc, 18);
      chk("to_busy", busy, 0);
      @(negedge CLK);
      chk("to_pulse", timeout_err, 0);
      chk("to_regrant", grant_id, 1);
      chk("to_regrant_busy", busy, 1);
      @(negedge CLK);
      chk("to_next_wen", tx_wen, 1);
      chk("to_next_data", tx_data, 8'hB1);
      req_valid = '0;
      repeat (3) @(negedge CLK);
      model_rr = 1;
`else
      acc = 1'b0;
      tcyc = 0;
`endif

      chk("ready_rules", bad_rdy, 0);
      chk("no_timeout", terr_seen, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
